ssd_scan_driver: RTL and testbench

//  Time-multiplexed driver for NUM_DIGITS common-anode seven-segment digits. Active-low outputs throughout.

---
 rtl/ssd_pkg.sv | 33 +++
 rtl/ssd_scan_driver_if.sv | 28 ++
 rtl/ssd_hex_font.sv | 12 +
 rtl/ssd_scan_driver.sv | 128 ++++++++++++
 tb/tb_ssd_scan_driver.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/ssd_pkg.sv
// rtl/ssd_pkg.sv - shared types, blank code and hex font for the seven-segment scan driver
// Contents: seg_t (g..a, active-low), SEG_BLANK, hex_font().
package ssd_pkg;

  typedef logic [6:0] seg_t;

  localparam seg_t SEG_BLANK = 7'h7F;

  // Active-low g..a patterns; lowercase b and d keep them distinct from 8 and 0.
  function automatic seg_t hex_font(input logic [3:0] nib);
    seg_t s;
    case (nib)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/ssd_scan_driver_if.sv
// rtl/ssd_scan_driver_if.sv - datapath/display bundle for the scan driver
// master: datapath side (drives value, load, blank_mask, blink_en, lz_en; sees seg_n, an_n, frame_done)
// slave : scan driver side
interface ssd_scan_driver_if #(
  parameter int NUM_DIGITS = 4
);
  import ssd_pkg::*;

  logic [4*NUM_DIGITS-1:0] value;
  logic                    load;
  logic [NUM_DIGITS-1:0]   blank_mask;
  logic [NUM_DIGITS-1:0]   blink_en;
  logic                    lz_en;
  seg_t                    seg_n;
  logic [NUM_DIGITS-1:0]   an_n;
  logic                    frame_done;

  modport master (
    output value, load, blank_mask, blink_en, lz_en,
    input  seg_n, an_n, frame_done
  );

  modport slave (
    input  value, load, blank_mask, blink_en, lz_en,
    output seg_n, an_n, frame_done
  );

endinterface

// File: rtl/ssd_hex_font.sv
// rtl/ssd_hex_font.sv - combinational 4-to-7 hex decoder, active-low g..a
// Ports: nibble (in, 4) -> seg (out, 7)
module ssd_hex_font
  import ssd_pkg::*;
(
  input  logic [3:0] nibble,
  output seg_t       seg
);

  assign seg = hex_font(nibble);

endmodule

// File: rtl/ssd_scan_driver.sv
// rtl/ssd_scan_driver.sv - time-multiplexed common-anode seven-segment driver
// Ports: clk, reset (async, active-high), bus (slave): value/load/blank_mask/blink_en/lz_en in,
//        seg_n/an_n/frame_done out. All display outputs are registered and active-low.
module ssd_scan_driver
  import ssd_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 50000,
  parameter int DEAD_CYCLES = 2,
  parameter int BLINK_LOG2  = 5
) (
  input logic              clk,
  input logic              reset,
  ssd_scan_driver_if.slave bus
);

  localparam int SLOT_W = $clog2(REFRESH_DIV);
  localparam int IDX_W  = $clog2(NUM_DIGITS);
  localparam int VAL_W  = 4 * NUM_DIGITS;

  logic [SLOT_W-1:0]     slot_cnt;
  logic [IDX_W-1:0]      idx;
  logic [BLINK_LOG2-1:0] frame_cnt;
  logic                  phase;
  logic                  slot_wrap;
  logic                  frame_end;

  logic [VAL_W-1:0]      pend_value, act_value;
  logic [NUM_DIGITS-1:0] pend_blank, act_blank;
  logic [NUM_DIGITS-1:0] pend_blink, act_blink;
  logic                  pend_lz, act_lz;

  logic [3:0]            nib;
  seg_t                  font_seg;
  logic                  lz;
  logic                  dark;
  seg_t                  seg_d, seg_q;
  logic [NUM_DIGITS-1:0] an_d, an_q;
  logic                  fd_q;

  assign slot_wrap = (slot_cnt == SLOT_W'(REFRESH_DIV - 1));
  assign frame_end = slot_wrap && (idx == IDX_W'(NUM_DIGITS - 1));

  // Scan counters: slot within a digit, digit index, frame count and blink phase.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      slot_cnt  <= '0;
      idx       <= '0;
      frame_cnt <= '0;
      phase     <= 1'b0;
    end else begin
      slot_cnt <= slot_wrap ? '0 : slot_cnt + 1'b1;
      if (slot_wrap) begin
        idx <= (idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx + 1'b1;
      end
      if (frame_end) begin
        frame_cnt <= frame_cnt + 1'b1;
        if (&frame_cnt) begin
          phase <= ~phase;
        end
      end
    end
  end

  // Double buffer. The active copy only changes on a frame boundary so a frame never
  // mixes old and new digits; a load on the boundary cycle is forwarded straight through.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend_value <= '0;
      pend_blank <= '0;
      pend_blink <= '0;
      pend_lz    <= 1'b0;
      act_value  <= '0;
      act_blank  <= '0;
      act_blink  <= '0;
      act_lz     <= 1'b0;
    end else begin
      if (bus.load) begin
        pend_value <= bus.value;
        pend_blank <= bus.blank_mask;
        pend_blink <= bus.blink_en;
        pend_lz    <= bus.lz_en;
      end
      if (frame_end) begin
        act_value <= bus.load ? bus.value      : pend_value;
        act_blank <= bus.load ? bus.blank_mask : pend_blank;
        act_blink <= bus.load ? bus.blink_en   : pend_blink;
        act_lz    <= bus.load ? bus.lz_en      : pend_lz;
      end
    end
  end

  ssd_hex_font u_font (
    .nibble (nib),
    .seg    (font_seg)
  );

  always_comb begin
    nib   = act_value[{idx, 2'b00} +: 4];
    // A digit is a leading zero when it and every more-significant nibble are zero.
    lz    = act_lz && (idx != '0) && ((act_value >> {idx, 2'b00}) == '0);
    dark  = act_blank[idx] || (act_blink[idx] && phase) || lz;
    seg_d = SEG_BLANK;
    an_d  = '1;
    // Anti-ghost: the first DEAD_CYCLES of every slot keep all anodes off.
    if (slot_cnt >= SLOT_W'(DEAD_CYCLES)) begin
      an_d[idx] = 1'b0;
      seg_d     = dark ? SEG_BLANK : font_seg;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      seg_q <= SEG_BLANK;
      an_q  <= '1;
      fd_q  <= 1'b0;
    end else begin
      seg_q <= seg_d;
      an_q  <= an_d;
      fd_q  <= frame_end;
    end
  end

  assign bus.seg_n      = seg_q;
  assign bus.an_n       = an_q;
  assign bus.frame_done = fd_q;

endmodule

// File: tb/tb_ssd_scan_driver.sv
// tb/tb_ssd_scan_driver.sv - self-checking bench for ssd_scan_driver against a cycle-count reference model
module tb_ssd_scan_driver;

  localparam int ND    = 4;
  localparam int RDIV  = 8;
  localparam int DEAD  = 1;
  localparam int BLOG2 = 1;
  localparam int FRAME = RDIV * ND;

  logic clk = 1'b0;
  logic reset = 1'b1;

  ssd_scan_driver_if #(.NUM_DIGITS(ND)) bus ();

  ssd_scan_driver #(
    .NUM_DIGITS  (ND),
    .REFRESH_DIV (RDIV),
    .DEAD_CYCLES (DEAD),
    .BLINK_LOG2  (BLOG2)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference state: cycles since reset release plus the two buffers.
  int          t = 0;
  logic [15:0] pend_v, act_v;
  logic [3:0]  pend_bm, act_bm, pend_be, act_be;
  logic        pend_lz, act_lz;
  logic [6:0]  font_tbl [16];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s t=%0d got=%0h exp=%0h", tag, t, got, exp);
    end
  endtask

  // Expected seg_n/an_n produced from scan position t, derived from time alone.
  function automatic void expect_out(output logic [6:0] es, output logic [3:0] ea);
    int   slot, d, f;
    logic ph, allz, dk;
    slot = t % RDIV;
    d    = (t / RDIV) % ND;
    f    = t / FRAME;
    ph   = ((f >> BLOG2) & 1) != 0;
    es   = 7'h7F;
    ea   = 4'hF;
    if (slot >= DEAD) begin
      ea[d] = 1'b0;
      allz  = 1'b1;
      for (int j = d; j < ND; j++) begin
        if (act_v[4*j +: 4] != 4'h0) allz = 1'b0;
      end
      dk = act_bm[d] | (act_be[d] & ph) | (act_lz & (d > 0) & allz);
      es = dk ? 7'h7F : font_tbl[act_v[4*d +: 4]];
    end
  endfunction

  task automatic model_clear();
    t = 0;
    pend_v = '0; act_v = '0; pend_bm = '0; act_bm = '0;
    pend_be = '0; act_be = '0; pend_lz = 1'b0; act_lz = 1'b0;
  endtask

  // Called just after a falling edge: drive, advance one clock, check at the next falling edge.
  task automatic step(input logic ld, input logic [15:0] v, input logic [3:0] bm,
                      input logic [3:0] be, input logic lz);
    logic [6:0] es;
    logic [3:0] ea;
    logic       efd;
    bus.load = ld; bus.value = v; bus.blank_mask = bm; bus.blink_en = be; bus.lz_en = lz;
    expect_out(es, ea);
    efd = (t % FRAME) == FRAME - 1;
    if (ld) begin
      pend_v = v; pend_bm = bm; pend_be = be; pend_lz = lz;
    end
    if (efd) begin
      act_v = pend_v; act_bm = pend_bm; act_be = pend_be; act_lz = pend_lz;
    end
    t++;
    @(negedge clk);
    check("seg_n", 32'(bus.seg_n), 32'(es));
    check("an_n", 32'(bus.an_n), 32'(ea));
    check("frame_done", 32'(bus.frame_done), 32'(efd));
  endtask

  // No load; the data inputs wander to show they are ignored.
  task automatic idle();
    step(1'b0, 16'($urandom), 4'($urandom), 4'($urandom), 1'($urandom));
  endtask

  task automatic load(input logic [15:0] v, input logic [3:0] bm, input logic [3:0] be, input logic lz);
    step(1'b1, v, bm, be, lz);
  endtask

  // Advance until the outputs show frame position pos (outputs lag the scan by one cycle).
  task automatic observe(input int pos);
    do idle(); while (((t - 1) % FRAME) != pos);
  endtask

  // Advance until the next step will be applied at frame position pos.
  task automatic run_to(input int pos);
    while ((t % FRAME) != pos) idle();
  endtask

  task automatic check_dark(input string tag);
    check({tag, "_seg"}, 32'(bus.seg_n), 32'h7F);
    check({tag, "_an"}, 32'(bus.an_n), 32'hF);
    check({tag, "_fd"}, 32'(bus.frame_done), 32'h0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout vectors=%0d", vectors);
    $fatal(1, "bench time limit");
  end

  initial begin
    font_tbl = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    bus.load = 1'b0; bus.value = '0; bus.blank_mask = '0; bus.blink_en = '0; bus.lz_en = 1'b0;
    model_clear();

    // 1. reset held three cycles, then the cleared buffer shows 0000
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_dark("rst_hold");
    end
    reset = 1'b0;
    observe(0);
    check("d0_dead_an", 32'(bus.an_n), 32'hF);
    observe(3);
    check("d0_zero_seg", 32'(bus.seg_n), 32'h40);
    check("d0_zero_an", 32'(bus.an_n), 32'hE);

    // 2. plain hex value
    load(16'h12AF, 4'h0, 4'h0, 1'b0);
    observe(3);  check("12AF_d0", 32'({bus.an_n, bus.seg_n}), 32'({4'hE, 7'h0E}));
    observe(11); check("12AF_d1", 32'({bus.an_n, bus.seg_n}), 32'({4'hD, 7'h08}));
    observe(19); check("12AF_d2", 32'({bus.an_n, bus.seg_n}), 32'({4'hB, 7'h24}));
    observe(27); check("12AF_d3", 32'({bus.an_n, bus.seg_n}), 32'({4'h7, 7'h79}));
    for (int i = 0; i < 2 * FRAME; i++) idle();

    // 3. leading-zero suppression
    load(16'h0030, 4'h0, 4'h0, 1'b1);
    observe(3);  check("lz_d0", 32'({bus.an_n, bus.seg_n}), 32'({4'hE, 7'h40}));
    observe(11); check("lz_d1", 32'({bus.an_n, bus.seg_n}), 32'({4'hD, 7'h30}));
    observe(19); check("lz_d2", 32'({bus.an_n, bus.seg_n}), 32'({4'hB, 7'h7F}));
    observe(27); check("lz_d3", 32'({bus.an_n, bus.seg_n}), 32'({4'h7, 7'h7F}));
    load(16'h0000, 4'h0, 4'h0, 1'b1);
    observe(3);  check("lz0_d0", 32'(bus.seg_n), 32'h40);
    observe(11); check("lz0_d1", 32'(bus.seg_n), 32'h7F);

    // 4. several loads in one frame, the last landing on the boundary cycle
    run_to(5);  load(16'h1111, 4'h0, 4'h0, 1'b0);
    run_to(16); load(16'h2222, 4'h0, 4'h0, 1'b0);
    run_to(FRAME - 1); load(16'h3333, 4'h0, 4'h0, 1'b0);
    observe(3);  check("bypass_d0", 32'(bus.seg_n), 32'h30);
    observe(27); check("bypass_d3", 32'(bus.seg_n), 32'h30);

    // 5. blink and blank over several blink periods
    load(16'h8888, 4'b1000, 4'b0001, 1'b0);
    for (int i = 0; i < 8 * FRAME; i++) idle();

    // 6. one-cycle reset in the middle of a d2 slot
    load(16'h9876, 4'h0, 4'h0, 1'b0);
    for (int i = 0; i < FRAME; i++) idle();
    observe(19);
    reset = 1'b1;
    #1;
    check_dark("rst_async");
    @(negedge clk);
    check_dark("rst_pulse");
    reset = 1'b0;
    model_clear();
    observe(3);
    check("rst_resume_d0", 32'({bus.an_n, bus.seg_n}), 32'({4'hE, 7'h40}));

    // Random traffic against the model
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 15) == 0) begin
        load(16'($urandom), 4'($urandom & $urandom), 4'($urandom), 1'($urandom));
      end else begin
        idle();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
